vram_access_arbiter: RTL

- Owns the single-port frame memory that feeds the VGA pixel path.
- Shares that memory between three users: the display scan-out (read), a drawing-engine writer (req/ack handshake) and a built-in bulk clear engine.
- Sits between the sync generator outputs (pixel_x, pixel_y, video_on, pixel tick) and the pixel generation stage. Its disp_rgb output becomes the framebuffer colour source.
- Display reads have absolute priority. Writes and clears use every other cycle.

---
 rtl/vram_access_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/vram_access_arbiter.sv
// Single-port frame memory arbiter for the VGA pixel path.
// Display scan-out reads take every pixel tick during active video. A drawing-engine
// writer (req/ack) and a bulk clear engine share the remaining cycles, clear first.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   pixel_x_i, pixel_y_i     current scan position from the sync generator
//   video_on_i, pixel_tick_i active region flag, one-clk pulse per pixel period
//   wr_req_i/addr/data       writer request, held until wr_ack_o is seen
//   wr_ack_o                 write issued this cycle (combinational)
//   clear_start_i            pulse: begin filling the framebuffer with clear_color_i
//   clear_busy_o/done_o      clear in progress / one-cycle completion pulse
//   wr_oor_o                 sticky: an out-of-range write was dropped
//   mem_*                    single-port memory interface (read data 1 clk latency)
//   disp_rgb_o               pixel colour for the pixel generation stage
module vram_access_arbiter #(
  parameter int unsigned FbWidth  = 160,
  parameter int unsigned FbHeight = 120,
  parameter int unsigned Shift    = 2,
  parameter int unsigned AddrW    = 15,
  parameter int unsigned DataW    = 12
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [9:0]       pixel_x_i,
  input  logic [9:0]       pixel_y_i,
  input  logic             video_on_i,
  input  logic             pixel_tick_i,
  input  logic             wr_req_i,
  input  logic [AddrW-1:0] wr_addr_i,
  input  logic [DataW-1:0] wr_data_i,
  output logic             wr_ack_o,
  input  logic             clear_start_i,
  input  logic [DataW-1:0] clear_color_i,
  output logic             clear_busy_o,
  output logic             clear_done_o,
  output logic             wr_oor_o,
  output logic             mem_en_o,
  output logic             mem_we_o,
  output logic [AddrW-1:0] mem_addr_o,
  output logic [DataW-1:0] mem_wdata_o,
  input  logic [DataW-1:0] mem_rdata_i,
  output logic [DataW-1:0] disp_rgb_o
);

  localparam int unsigned      FbSize   = FbWidth * FbHeight;
  localparam logic [AddrW-1:0] LastAddr = AddrW'(FbSize - 1);

  typedef enum logic {StIdle, StClear} state_e;

  state_e           state_q, state_d;
  logic [AddrW-1:0] clr_addr_q, clr_addr_d;
  logic [DataW-1:0] clr_color_q, clr_color_d;
  logic [DataW-1:0] disp_rgb_q, disp_rgb_d;
  logic             clear_busy_q, clear_busy_d;
  logic             clear_done_q, clear_done_d;
  logic             wr_oor_q, wr_oor_d;
  logic             rd_pending_q;

  logic             disp_slot;
  logic             wr_in_range;
  logic [AddrW-1:0] disp_addr;

  assign disp_slot   = video_on_i & pixel_tick_i;
  assign wr_in_range = 32'(wr_addr_i) < FbSize;
  assign disp_addr   = AddrW'(32'(pixel_y_i >> Shift) * FbWidth + 32'(pixel_x_i >> Shift));

  // Memory port mux; everything is gated off while reset is held.
  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    wr_ack_o    = 1'b0;
    if (!rst_ni) begin
      mem_en_o = 1'b0;
    end else if (disp_slot) begin
      mem_en_o   = 1'b1;
      mem_addr_o = disp_addr;
    end else if (state_q == StClear) begin
      mem_en_o    = 1'b1;
      mem_we_o    = 1'b1;
      mem_addr_o  = clr_addr_q;
      mem_wdata_o = clr_color_q;
    end else if (wr_req_i) begin
      // Out-of-range writes are acked so the requester never stalls, but dropped.
      wr_ack_o = 1'b1;
      if (wr_in_range) begin
        mem_en_o    = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = wr_addr_i;
        mem_wdata_o = wr_data_i;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    clr_addr_d   = clr_addr_q;
    clr_color_d  = clr_color_q;
    clear_busy_d = clear_busy_q;
    clear_done_d = 1'b0;
    wr_oor_d     = wr_oor_q | (wr_ack_o & ~wr_in_range);
    disp_rgb_d   = disp_rgb_q;

    unique case (state_q)
      StIdle: begin
        if (clear_start_i) begin
          state_d      = StClear;
          clr_color_d  = clear_color_i;
          clr_addr_d   = '0;
          clear_busy_d = 1'b1;
        end
      end
      StClear: begin
        // A display slot stalls the clear with clr_addr held.
        if (!disp_slot) begin
          clr_addr_d = clr_addr_q + 1'b1;
          if (clr_addr_q == LastAddr) begin
            state_d      = StIdle;
            clr_addr_d   = '0;
            clear_busy_d = 1'b0;
            clear_done_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Read data arrives the cycle after the display slot.
    if (rd_pending_q) begin
      disp_rgb_d = mem_rdata_i;
    end else if (pixel_tick_i && !video_on_i) begin
      disp_rgb_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      clr_addr_q   <= '0;
      clr_color_q  <= '0;
      disp_rgb_q   <= '0;
      clear_busy_q <= 1'b0;
      clear_done_q <= 1'b0;
      wr_oor_q     <= 1'b0;
      rd_pending_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      clr_color_q  <= clr_color_d;
      disp_rgb_q   <= disp_rgb_d;
      clear_busy_q <= clear_busy_d;
      clear_done_q <= clear_done_d;
      wr_oor_q     <= wr_oor_d;
      rd_pending_q <= disp_slot;
    end
  end

  assign clear_busy_o = clear_busy_q;
  assign clear_done_o = clear_done_q;
  assign wr_oor_o     = wr_oor_q;
  assign disp_rgb_o   = disp_rgb_q;

endmodule
